// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with fused ALU-control decode, valid/ready handshake,
// a registered one-entry result buffer and an optional iterative shift-add multiplier.
//
// Optional feature macro: ALU_EXEC_MUL_EN
//   defined   -> R-type fn7=0000001 decodes as mul, executed over WIDTH cycles (MUL state).
//   undefined -> that encoding is illegal (result 0, latency 1); no multiplier hardware.
//
// Parameters:
//   WIDTH  operand/result width (power of two, >= 8)
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready input handshake; an op transfers when both are high
//   alu_op, opcode,   ALUOp from main decoder, instruction opcode (only bit 5 used),
//   fn3, fn7          funct3, funct7
//   op_a, op_b        operands (rs1, rs2/immediate)
//   out_valid/out_ready output handshake; result held until consumed
//   result, zero      registered result and result==0 flag
//   alu_ctrl, illegal decoded control of the held result, illegal-encoding flag
module alu_exec_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       alu_op,
   input  logic [6:0]       opcode,
   input  logic [2:0]       fn3,
   input  logic [6:0]       fn7,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [3:0]       alu_ctrl,
   output logic             illegal
);

   localparam int unsigned SHW = $clog2(WIDTH);

   typedef enum logic [3:0] {
      CtlAdd   = 4'b0000,
      CtlSub   = 4'b0001,
      CtlAnd   = 4'b0010,
      CtlOr    = 4'b0011,
      CtlXor   = 4'b0100,
      CtlPassB = 4'b0101,
      CtlSll   = 4'b0110,
      CtlSrl   = 4'b0111,
      CtlSra   = 4'b1000,
      CtlSlt   = 4'b1001,
      CtlSltu  = 4'b1010,
      CtlMul   = 4'b1011
   } ctrl_e;

   // funct3 decode shared by I-type and R-type; sub only exists for R-type.
   function automatic ctrl_e f3_ctrl(input logic [2:0] f3, input logic alt, input logic rtype);
      case (f3)
         3'b000:  f3_ctrl = (rtype && alt) ? CtlSub : CtlAdd;
         3'b001:  f3_ctrl = CtlSll;
         3'b101:  f3_ctrl = alt ? CtlSra : CtlSrl;
         3'b111:  f3_ctrl = CtlAnd;
         3'b110:  f3_ctrl = CtlOr;
         3'b100:  f3_ctrl = CtlXor;
         3'b010:  f3_ctrl = CtlSlt;
         default: f3_ctrl = CtlSltu;
      endcase
   endfunction

   // ---------------------------------------------------------------- decode
   ctrl_e w_ctrl;
   logic  w_illegal;

   always_comb begin
      w_ctrl    = CtlAdd;
      w_illegal = 1'b0;
      case (alu_op)
         2'b00: begin
            if (!opcode[5]) w_ctrl = f3_ctrl(fn3, fn7[5], 1'b0);
         end
         2'b01: w_ctrl = CtlSub;
         2'b10: begin
            if (fn7 == 7'b0000001) begin
`ifdef ALU_EXEC_MUL_EN
               w_ctrl = CtlMul;
`else
               w_illegal = 1'b1;
`endif
            end else if (fn7 == 7'b0000000 || fn7 == 7'b0100000) begin
               w_ctrl = f3_ctrl(fn3, fn7[5], 1'b1);
            end else begin
               w_illegal = 1'b1;
            end
         end
         default: begin
            if (opcode[5]) w_ctrl = CtlPassB;
         end
      endcase
   end

   // Only opcode[5] distinguishes lui from the other alu_op=11 users.
   logic w_unused_opcode;
   assign w_unused_opcode = ^{opcode[6], opcode[4:0]};

   // --------------------------------------------------------------- execute
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_alu_res;

   assign w_shamt = op_b[SHW-1:0];

   always_comb begin
      w_alu_res = '0;
      if (!w_illegal) begin
         case (w_ctrl)
            CtlAdd:   w_alu_res = op_a + op_b;
            CtlSub:   w_alu_res = op_a - op_b;
            CtlAnd:   w_alu_res = op_a & op_b;
            CtlOr:    w_alu_res = op_a | op_b;
            CtlXor:   w_alu_res = op_a ^ op_b;
            CtlPassB: w_alu_res = op_b;
            CtlSll:   w_alu_res = op_a << w_shamt;
            CtlSrl:   w_alu_res = op_a >> w_shamt;
            CtlSra:   w_alu_res = $unsigned($signed(op_a) >>> w_shamt);
            CtlSlt:   w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            CtlSltu:  w_alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            default:  w_alu_res = '0;
         endcase
      end
   end

   // ------------------------------------------------------------- handshake
   logic w_idle;
   logic w_mul_done;
   logic [WIDTH-1:0] w_mul_res;
   logic w_accept;
   logic w_start_mul;
   logic r_out_valid;

   assign in_ready    = rst_n && w_idle && (!r_out_valid || out_ready);
   assign w_accept    = in_valid && in_ready;
   assign w_start_mul = w_accept && (w_ctrl == CtlMul);

   // ------------------------------------------------------------ multiplier
`ifdef ALU_EXEC_MUL_EN
   typedef enum logic {StIdle, StMul} state_e;

   state_e           r_state, w_state_next;
   logic [SHW-1:0]   r_cnt, w_cnt_next;
   logic [WIDTH-1:0] r_acc, w_acc_next;
   logic [WIDTH-1:0] r_mcand, w_mcand_next;
   logic [WIDTH-1:0] r_mplier, w_mplier_next;
   logic [WIDTH-1:0] w_acc_sum;

   // Multiplicand shifts left, multiplier right; add when the multiplier LSB is set.
   assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_idle    = (r_state == StIdle);
   assign w_mul_res = w_acc_sum;

   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_acc_next    = r_acc;
      w_mcand_next  = r_mcand;
      w_mplier_next = r_mplier;
      w_mul_done    = 1'b0;
      case (r_state)
         StIdle: begin
            if (w_start_mul) begin
               w_state_next  = StMul;
               w_cnt_next    = '0;
               w_acc_next    = '0;
               w_mcand_next  = op_a;
               w_mplier_next = op_b;
            end
         end
         default: begin
            w_acc_next    = w_acc_sum;
            w_mcand_next  = r_mcand << 1;
            w_mplier_next = r_mplier >> 1;
            w_cnt_next    = r_cnt + 1'b1;
            if (r_cnt == SHW'(WIDTH - 1)) begin
               w_mul_done   = 1'b1;
               w_state_next = StIdle;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_acc    <= w_acc_next;
         r_mcand  <= w_mcand_next;
         r_mplier <= w_mplier_next;
      end
   end
`else
   assign w_idle     = 1'b1;
   assign w_mul_done = 1'b0;
   assign w_mul_res  = '0;
`endif

   // --------------------------------------------------------- result buffer
   logic [WIDTH-1:0] r_result, w_result_next;
   logic             r_zero, w_zero_next;
   ctrl_e            r_ctrl, w_ctrl_next;
   logic             r_illegal, w_illegal_next;
   logic             w_out_valid_next;

   always_comb begin
      w_result_next    = r_result;
      w_zero_next      = r_zero;
      w_ctrl_next      = r_ctrl;
      w_illegal_next   = r_illegal;
      w_out_valid_next = r_out_valid;
      if (w_accept && !w_start_mul) begin
         // Also covers consume+accept in the same cycle: new result replaces old.
         w_result_next    = w_alu_res;
         w_zero_next      = (w_alu_res == '0);
         w_ctrl_next      = w_ctrl;
         w_illegal_next   = w_illegal;
         w_out_valid_next = 1'b1;
      end else if (w_mul_done) begin
         w_result_next    = w_mul_res;
         w_zero_next      = (w_mul_res == '0);
         w_ctrl_next      = CtlMul;
         w_illegal_next   = 1'b0;
         w_out_valid_next = 1'b1;
      end else if (r_out_valid && out_ready) begin
         w_out_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_ctrl      <= CtlAdd;
         r_illegal   <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_result    <= w_result_next;
         r_zero      <= w_zero_next;
         r_ctrl      <= w_ctrl_next;
         r_illegal   <= w_illegal_next;
         r_out_valid <= w_out_valid_next;
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign zero      = r_zero;
   assign alu_ctrl  = r_ctrl;
   assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus a randomized stream
// compared against a behavioural model through an in-order scoreboard.
module tb_alu_exec_unit;
   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    alu_op = '0;
   logic [6:0]    opcode = '0;
   logic [2:0]    fn3 = '0;
   logic [6:0]    fn7 = '0;
   logic [W-1:0]  op_a = '0;
   logic [W-1:0]  op_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result;
   logic          zero;
   logic [3:0]    alu_ctrl;
   logic          illegal;

   int n_pass = 0;
   int n_total = 0;

   alu_exec_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .opcode(opcode), .fn3(fn3), .fn7(fn7),
      .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .alu_ctrl(alu_ctrl), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] res;
      logic [3:0]   ctrl;
      logic         ill;
   } exp_t;

   // Behavioural model: name the operation from the decode rules, then evaluate it.
   function automatic exp_t ref_model(input logic [1:0] aop, input logic [6:0] opc,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      string op;
      int sh;
      logic signed [W-1:0] sa;
      logic signed [W-1:0] sb;
      sa = a;
      sb = b;
      sh = int'(b % W);
      op = "add";
      if (aop == 2'd1) op = "sub";
      else if (aop == 2'd3) op = opc[5] ? "passb" : "add";
      else if (aop == 2'd0 && !opc[5] || aop == 2'd2) begin
         if (aop == 2'd2 && f7 == 7'd1) begin
`ifdef ALU_EXEC_MUL_EN
            op = "mul";
`else
            op = "illegal";
`endif
         end else if (aop == 2'd2 && f7 != 7'h00 && f7 != 7'h20) op = "illegal";
         else if (f3 == 3'd0) op = (aop == 2'd2 && f7[5]) ? "sub" : "add";
         else if (f3 == 3'd1) op = "sll";
         else if (f3 == 3'd5) op = f7[5] ? "sra" : "srl";
         else if (f3 == 3'd7) op = "and";
         else if (f3 == 3'd6) op = "or";
         else if (f3 == 3'd4) op = "xor";
         else if (f3 == 3'd2) op = "slt";
         else op = "sltu";
      end
      e.ill = 1'b0;
      if (op == "add")        begin e.res = a + b;                 e.ctrl = 4'd0;  end
      else if (op == "sub")   begin e.res = a - b;                 e.ctrl = 4'd1;  end
      else if (op == "and")   begin e.res = a & b;                 e.ctrl = 4'd2;  end
      else if (op == "or")    begin e.res = a | b;                 e.ctrl = 4'd3;  end
      else if (op == "xor")   begin e.res = a ^ b;                 e.ctrl = 4'd4;  end
      else if (op == "passb") begin e.res = b;                     e.ctrl = 4'd5;  end
      else if (op == "sll")   begin e.res = a << sh;               e.ctrl = 4'd6;  end
      else if (op == "srl")   begin e.res = a >> sh;               e.ctrl = 4'd7;  end
      else if (op == "sra")   begin e.res = W'(sa >>> sh);         e.ctrl = 4'd8;  end
      else if (op == "slt")   begin e.res = (sa < sb) ? 1 : 0;     e.ctrl = 4'd9;  end
      else if (op == "sltu")  begin e.res = (a < b) ? 1 : 0;       e.ctrl = 4'd10; end
      else if (op == "mul")   begin e.res = a * b;                 e.ctrl = 4'd11; end
      else begin e.res = '0; e.ctrl = 4'd0; e.ill = 1'b1; end
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op and hold it until accepted; returns 1 ns after the accepting edge.
   task automatic issue(input logic [1:0] aop, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [W-1:0] a, input logic [W-1:0] b);
      int guard;
      alu_op = aop; opcode = opc; fn3 = f3; fn7 = f7; op_a = a; op_b = b;
      in_valid = 1'b1;
      #1;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk);
         #2;
         guard++;
      end
      n_total++;
      if (guard >= 100) $display("FAIL issue_timeout: in_ready stayed %b, required 1", in_ready);
      else n_pass++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      alu_op = 2'b10; opcode = 7'h33; fn3 = 3'd0; fn7 = 7'h00; op_a = 32'd9; op_b = 32'd9;
      in_valid = 1'b1;
      repeat (2) tick();
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid);
      else n_pass++;
      n_total++;
      if (result !== '0) $display("FAIL reset_result: got %h, required 0", result);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b, required 0", in_ready);
      else n_pass++;
      rst_n = 1'b1;
      in_valid = 1'b0;
      #1;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b, required 1", in_ready);
      else n_pass++;
      out_ready = 1'b1;
   endtask

   task automatic test_rtype();
      issue(2'b10, 7'h33, 3'd0, 7'h20, 32'd5, 32'd7);
      n_total++;
      if ({out_valid, result, alu_ctrl, zero} !== {1'b1, 32'hFFFF_FFFE, 4'b0001, 1'b0})
         $display("FAIL rtype_sub: got v=%b r=%h c=%h z=%b, required v=1 r=fffffffe c=1 z=0",
                  out_valid, result, alu_ctrl, zero);
      else n_pass++;
      issue(2'b10, 7'h33, 3'd0, 7'h00, 32'd5, 32'd7);
      n_total++;
      if ({out_valid, result, alu_ctrl} !== {1'b1, 32'd12, 4'b0000})
         $display("FAIL rtype_add: got v=%b r=%h c=%h, required v=1 r=0000000c c=0",
                  out_valid, result, alu_ctrl);
      else n_pass++;
   endtask

   task automatic test_shift_cmp();
      issue(2'b00, 7'h13, 3'd5, 7'h20, 32'h8000_0000, 32'd4);
      n_total++;
      if ({result, alu_ctrl} !== {32'hF800_0000, 4'b1000})
         $display("FAIL itype_sra: got r=%h c=%h, required r=f8000000 c=8", result, alu_ctrl);
      else n_pass++;
      issue(2'b10, 7'h33, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1);
      n_total++;
      if (result !== 32'd1) $display("FAIL slt_neg: got %h, required 00000001", result);
      else n_pass++;
      issue(2'b10, 7'h33, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1);
      n_total++;
      if ({result, zero} !== {32'd0, 1'b1})
         $display("FAIL sltu_neg: got r=%h z=%b, required r=0 z=1", result, zero);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      issue(2'b10, 7'h33, 3'd0, 7'h00, 32'd1, 32'd2);
      alu_op = 2'b10; opcode = 7'h33; fn3 = 3'd4; fn7 = 7'h00; op_a = 32'hF0; op_b = 32'h0F;
      in_valid = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if ({out_valid, result} !== {1'b1, 32'd3})
            $display("FAIL hold_result[%0d]: got v=%b r=%h, required v=1 r=00000003",
                     i, out_valid, result);
         else n_pass++;
         n_total++;
         if (in_ready !== 1'b0) $display("FAIL hold_in_ready[%0d]: got %b, required 0", i, in_ready);
         else n_pass++;
         @(posedge clk);
         #2;
      end
      out_ready = 1'b1;
      #1;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b, required 1", in_ready);
      else n_pass++;
      tick();
      in_valid = 1'b0;
      n_total++;
      if ({out_valid, result, alu_ctrl} !== {1'b1, 32'hFF, 4'b0100})
         $display("FAIL back_to_back: got v=%b r=%h c=%h, required v=1 r=000000ff c=4",
                  out_valid, result, alu_ctrl);
      else n_pass++;
   endtask

   task automatic test_mul();
      int cnt;
      int bad_ready;
      bit seen;
      out_ready = 1'b1;
`ifdef ALU_EXEC_MUL_EN
      issue(2'b10, 7'h33, 3'd0, 7'h01, 32'hFFFF_FFFF, 32'd3);
      cnt = 0;
      bad_ready = 0;
      while (!out_valid && cnt < 200) begin
         if (in_ready !== 1'b0) bad_ready++;
         tick();
         cnt++;
      end
      n_total++;
      if (cnt != W) $display("FAIL mul_latency: got %0d edges after accept, required %0d", cnt, W);
      else n_pass++;
      n_total++;
      if (bad_ready != 0) $display("FAIL mul_in_ready: got %0d ready cycles, required 0", bad_ready);
      else n_pass++;
      n_total++;
      if ({result, alu_ctrl, illegal} !== {32'hFFFF_FFFD, 4'b1011, 1'b0})
         $display("FAIL mul_result: got r=%h c=%h i=%b, required r=fffffffd c=b i=0",
                  result, alu_ctrl, illegal);
      else n_pass++;
      issue(2'b10, 7'h33, 3'd0, 7'h01, 32'd7, 32'd6);
      repeat (9) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         if (out_valid) seen = 1'b1;
         tick();
      end
      n_total++;
      if (seen) $display("FAIL mul_reset_abort: got out_valid=1, required 0");
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL mul_reset_ready: got %b, required 1", in_ready);
      else n_pass++;
`else
      issue(2'b10, 7'h33, 3'd0, 7'h01, 32'hFFFF_FFFF, 32'd3);
      n_total++;
      if ({out_valid, illegal, result} !== {1'b1, 1'b1, 32'd0})
         $display("FAIL mul_disabled: got v=%b i=%b r=%h, required v=1 i=1 r=0",
                  out_valid, illegal, result);
      else n_pass++;
`endif
   endtask

   task automatic test_illegal_lui();
      issue(2'b10, 7'h33, 3'd0, 7'h10, 32'd3, 32'd4);
      n_total++;
      if ({illegal, result, zero} !== {1'b1, 32'd0, 1'b1})
         $display("FAIL illegal_fn7: got i=%b r=%h z=%b, required i=1 r=0 z=1",
                  illegal, result, zero);
      else n_pass++;
      issue(2'b11, 7'h37, 3'd0, 7'h00, 32'hDEAD_BEEF, 32'h1234_5000);
      n_total++;
      if ({result, alu_ctrl, illegal} !== {32'h1234_5000, 4'b0101, 1'b0})
         $display("FAIL lui: got r=%h c=%h i=%b, required r=12345000 c=5 i=0",
                  result, alu_ctrl, illegal);
      else n_pass++;
   endtask

   task automatic test_random();
      exp_t q[$];
      exp_t e;
      logic [6:0] opcs [6];
      int accepted;
      int guard;
      opcs[0] = 7'h33; opcs[1] = 7'h13; opcs[2] = 7'h03;
      opcs[3] = 7'h23; opcs[4] = 7'h63; opcs[5] = 7'h37;
      accepted = 0;
      out_ready = 1'b1;
      tick();
      for (int cyc = 0; cyc < 4000 && accepted < 80; cyc++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         alu_op = 2'($urandom_range(0, 3));
         opcode = opcs[$urandom_range(0, 5)];
         fn3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: fn7 = 7'h00;
            1: fn7 = 7'h20;
            2: fn7 = 7'h01;
            default: fn7 = 7'($urandom);
         endcase
         op_a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 4)) : W'($urandom);
         op_b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 4)) : W'($urandom);
         #1;
         if (out_valid && out_ready) begin
            n_total++;
            if (q.size() == 0) begin
               $display("FAIL rand_spurious: got out_valid=1 r=%h, required no pending result",
                        result);
            end else begin
               e = q.pop_front();
               if ({result, alu_ctrl, illegal, zero} !== {e.res, e.ctrl, e.ill, (e.res == '0)})
                  $display("FAIL rand_result: got r=%h c=%h i=%b z=%b, required r=%h c=%h i=%b",
                           result, alu_ctrl, illegal, zero, e.res, e.ctrl, e.ill);
               else n_pass++;
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(ref_model(alu_op, opcode, fn3, fn7, op_a, op_b));
            accepted++;
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while (q.size() != 0 && guard < 200) begin
         #1;
         if (out_valid) begin
            e = q.pop_front();
            n_total++;
            if ({result, alu_ctrl, illegal} !== {e.res, e.ctrl, e.ill})
               $display("FAIL rand_drain: got r=%h c=%h i=%b, required r=%h c=%h i=%b",
                        result, alu_ctrl, illegal, e.res, e.ctrl, e.ill);
            else n_pass++;
         end
         tick();
         guard++;
      end
      n_total++;
      if (q.size() != 0) $display("FAIL rand_pending: got %0d results missing, required 0", q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_shift_cmp();
      test_back_to_back();
      test_mul();
      test_illegal_lui();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at time limit, required completion");
      $fatal(1, "timeout");
   end

endmodule
